// File: rtl/mmio_uart.sv
// mmio_uart: memory-mapped 8N1 UART with TX and RX FIFOs.
//
// Register map (word offsets on reg_addr):
//   0 DATA   write: push wdata[7:0] to TX FIFO (dropped when full)
//            read : {23'b0, rx_nonempty, head byte}; pops RX FIFO, reads 0 when empty
//   1 STATUS bit0 rx_nonempty, bit1 rx_full, bit2 tx_empty, bit8 tx_full,
//            bit9 tx_busy, bit10 overrun, bit11 frame_err, [31:16] RX occupancy
//   2 CTRL   bit0 rx_ie, bit1 tx_ie (read/write); bit2 clears errors; bit3 flushes FIFOs
//   3 reserved, reads 0
//
// Ports:
//   clk        system clock, rising edge
//   resetn     synchronous active-low reset
//   sel        bus access targets this block
//   reg_addr   word offset
//   wdata      write data
//   wstrb      one-cycle write strobe (qualified by sel)
//   rstrb      one-cycle read strobe (qualified by sel)
//   rdata      registered read data, valid the cycle after rstrb
//   txd        serial transmit line, idle high
//   rxd        asynchronous serial receive line
//   irq        (rx_nonempty & rx_ie) | (tx_empty & tx_ie)
module mmio_uart #(
  parameter int CLK_FREQ_HZ = 12000000,
  parameter int BAUD_RATE   = 115200,
  parameter int TX_DEPTH    = 16,
  parameter int RX_DEPTH    = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sel,
  input  logic [1:0]  reg_addr,
  input  logic [31:0] wdata,
  input  logic        wstrb,
  input  logic        rstrb,
  output logic [31:0] rdata,
  output logic        txd,
  input  logic        rxd,
  output logic        irq
);

  localparam int DIV  = CLK_FREQ_HZ / BAUD_RATE;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);
  localparam int TAW  = $clog2(TX_DEPTH);
  localparam int RAW  = $clog2(RX_DEPTH);

  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [TAW:0]  TX_ONE   = (TAW+1)'(1);
  localparam logic [RAW:0]  RX_ONE   = (RAW+1)'(1);

  if (DIV < 4) begin : g_bad_div
    $error("mmio_uart: CLK_FREQ_HZ/BAUD_RATE must be at least 4");
  end
  if (TX_DEPTH < 2 || (TX_DEPTH & (TX_DEPTH - 1)) != 0) begin : g_bad_tx_depth
    $error("mmio_uart: TX_DEPTH must be a power of 2, at least 2");
  end
  if (RX_DEPTH < 2 || (RX_DEPTH & (RX_DEPTH - 1)) != 0) begin : g_bad_rx_depth
    $error("mmio_uart: RX_DEPTH must be a power of 2, at least 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // ---------------------------------------------------------------- bus decode
  logic wr_en, rd_en, data_wr, ctrl_wr, data_rd, flush, err_clr;
  logic unused_wdata;

  assign wr_en   = sel & wstrb;
  assign rd_en   = sel & rstrb;
  assign data_wr = wr_en && (reg_addr == 2'd0);
  assign ctrl_wr = wr_en && (reg_addr == 2'd2);
  assign data_rd = rd_en && (reg_addr == 2'd0);
  assign flush   = ctrl_wr & wdata[3];
  assign err_clr = ctrl_wr & wdata[2];
  assign unused_wdata = ^wdata[31:8];

  // ---------------------------------------------------------------- TX FIFO
  logic [7:0]   tx_mem [TX_DEPTH];
  logic [TAW:0] tx_wr_q, tx_rd_q;
  logic         tx_empty, tx_full, tx_push, tx_pop, tx_avail;

  assign tx_empty = (tx_wr_q == tx_rd_q);
  assign tx_full  = (tx_wr_q[TAW] != tx_rd_q[TAW]) &&
                    (tx_wr_q[TAW-1:0] == tx_rd_q[TAW-1:0]);
  // A pop in the same cycle frees a slot, so a push on full still lands.
  assign tx_push  = data_wr && (!tx_full || tx_pop);
  // A flush cycle must not start a new frame from the entries being discarded.
  assign tx_avail = !tx_empty && !flush;

  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      tx_wr_q <= '0;
      tx_rd_q <= '0;
    end else begin
      if (tx_push) tx_wr_q <= tx_wr_q + TX_ONE;
      if (tx_pop)  tx_rd_q <= tx_rd_q + TX_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_q[TAW-1:0]] <= wdata[7:0];
  end

  // ---------------------------------------------------------------- TX FSM
  state_t        tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q;
  logic          tx_shift_en, tx_last;

  assign tx_last = (tx_cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
    end
  end

  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q + CNT_ONE;
    tx_bit_d    = tx_bit_q;
    tx_pop      = 1'b0;
    tx_shift_en = 1'b0;
    case (tx_state_q)
      S_IDLE: begin
        tx_cnt_d = '0;
        if (tx_avail) begin
          tx_state_d = S_START;
          tx_pop     = 1'b1;
        end
      end
      S_START: begin
        if (tx_last) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (tx_last) begin
          tx_cnt_d    = '0;
          tx_shift_en = 1'b1;
          if (tx_bit_q == 3'd7) tx_state_d = S_STOP;
          else                  tx_bit_d   = tx_bit_q + 3'd1;
        end
      end
      S_STOP: begin
        if (tx_last) begin
          tx_cnt_d = '0;
          // Chain straight into the next start bit when more data is queued.
          if (tx_avail) begin
            tx_state_d = S_START;
            tx_pop     = 1'b1;
          end else begin
            tx_state_d = S_IDLE;
          end
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  always_comb begin
    txd = 1'b1;
    case (tx_state_q)
      S_START: txd = 1'b0;
      S_DATA:  txd = tx_shift_q[0];
      default: txd = 1'b1;
    endcase
  end

  // The head byte is captured as it is popped; bits leave LSB first.
  always_ff @(posedge clk) begin
    if (tx_pop)           tx_shift_q <= tx_mem[tx_rd_q[TAW-1:0]];
    else if (tx_shift_en) tx_shift_q <= {1'b0, tx_shift_q[7:1]};
  end

  // ---------------------------------------------------------------- RX front end
  logic rx_meta_q, rx_sync_q, rx_prev_q, rx_fall;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rxd;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign rx_fall = rx_prev_q & ~rx_sync_q;

  // ---------------------------------------------------------------- RX FSM
  state_t        rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q;
  logic          rx_sample_en, rx_push_req, rx_ferr, rx_last;

  assign rx_last = (rx_cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
    end
  end

  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q + CNT_ONE;
    rx_bit_d     = rx_bit_q;
    rx_sample_en = 1'b0;
    rx_push_req  = 1'b0;
    rx_ferr      = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        rx_cnt_d = '0;
        if (rx_fall) rx_state_d = S_START;
      end
      S_START: begin
        // Mid start bit: a high line means the edge was a glitch.
        if (rx_cnt_q == CNT_HALF) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
          rx_state_d = rx_sync_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (rx_last) begin
          rx_cnt_d     = '0;
          rx_sample_en = 1'b1;
          if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end
      end
      S_STOP: begin
        if (rx_last) begin
          rx_cnt_d   = '0;
          rx_state_d = S_IDLE;
          if (rx_sync_q) rx_push_req = 1'b1;
          else           rx_ferr     = 1'b1;
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
    // Flushing abandons any byte being assembled.
    if (flush) begin
      rx_state_d  = S_IDLE;
      rx_cnt_d    = '0;
      rx_push_req = 1'b0;
      rx_ferr     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_sample_en) rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
  end

  // ---------------------------------------------------------------- RX FIFO
  logic [7:0]   rx_mem [RX_DEPTH];
  logic [RAW:0] rx_wr_q, rx_rd_q, rx_occ;
  logic         rx_empty, rx_full, rx_push, rx_pop, overrun_set;

  assign rx_empty    = (rx_wr_q == rx_rd_q);
  assign rx_full     = (rx_wr_q[RAW] != rx_rd_q[RAW]) &&
                       (rx_wr_q[RAW-1:0] == rx_rd_q[RAW-1:0]);
  assign rx_occ      = rx_wr_q - rx_rd_q;
  assign rx_pop      = data_rd && !rx_empty;
  assign rx_push     = rx_push_req && (!rx_full || rx_pop);
  assign overrun_set = rx_push_req && rx_full && !rx_pop;

  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      rx_wr_q <= '0;
      rx_rd_q <= '0;
    end else begin
      if (rx_push) rx_wr_q <= rx_wr_q + RX_ONE;
      if (rx_pop)  rx_rd_q <= rx_rd_q + RX_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_q[RAW-1:0]] <= rx_shift_q;
  end

  // ---------------------------------------------------------------- control / status
  logic rx_ie_q, tx_ie_q, overrun_q, frame_err_q;
  logic [31:0] status, rdata_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_ie_q     <= 1'b0;
      tx_ie_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        rx_ie_q <= wdata[0];
        tx_ie_q <= wdata[1];
      end
      // A fresh error in the clearing cycle keeps the flag set.
      if (overrun_set)  overrun_q <= 1'b1;
      else if (err_clr) overrun_q <= 1'b0;
      if (rx_ferr)      frame_err_q <= 1'b1;
      else if (err_clr) frame_err_q <= 1'b0;
    end
  end

  always_comb begin
    status        = '0;
    status[0]     = !rx_empty;
    status[1]     = rx_full;
    status[2]     = tx_empty;
    status[8]     = tx_full;
    status[9]     = tx_full || (tx_state_q != S_IDLE);
    status[10]    = overrun_q;
    status[11]    = frame_err_q;
    status[31:16] = 16'(rx_occ);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rdata_q <= '0;
    end else if (rd_en) begin
      case (reg_addr)
        2'd0:    rdata_q <= rx_empty ? 32'd0 : {23'd0, 1'b1, rx_mem[rx_rd_q[RAW-1:0]]};
        2'd1:    rdata_q <= status;
        2'd2:    rdata_q <= {30'd0, tx_ie_q, rx_ie_q};
        default: rdata_q <= 32'd0;
      endcase
    end
  end

  assign rdata = rdata_q;
  assign irq   = (!rx_empty & rx_ie_q) | (tx_empty & tx_ie_q);

endmodule
